data_ram_resp: RTL and testbench
================================

// Module: data_ram_resp
// PURPOSE
//  Data-memory responder: the slave end of the CPU data-memory port.
//  Accepts single-beat read/write requests (ena/wea/addra/dina), serves them from
//  internal word storage after a fixed wait-state count, returns douta with a
//  one-cycle ready pulse. Sits beside the CPU in the top level, replacing the fixed-latency RAM.
// PARAMETERS
//  DEPTH_LOG2   10  log2 of the number of 32-bit words in storage
//  WAIT_CYCLES  1   wait states between accept and response, legal range 0..15
// PORTS
//  clk    in   1   system clock, all state updates on rising edge
//  rst    in   1   asynchronous, active-low reset
//  ena    in   1   request strobe, sampled only in IDLE
//  wea    in   4   byte write enables; 4'b0000 = read, nonzero = write
//  addra  in   32  byte address
//  dina   in   32  write data, lane i = dina[8i+7:8i]
//  douta  out  32  read data, valid when ready=1
//  ready  out  1   one-cycle completion pulse
//  busy   out  1   high from the cycle after accept until ready has pulsed
//  err    out  1   alignment error, pulses with ready (DMEM_ALIGN_CHECK_EN only)
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, douta=0, ready=0, busy=0, err=0, wait counter=0.
//    Storage contents are not reset. A request in flight is dropped and its write is not committed.
//  - FSM IDLE -> WAIT -> RESP -> IDLE.
//    IDLE: ena=1 latches addra/wea/dina, loads counter with WAIT_CYCLES.
//      Next state is WAIT, or RESP if WAIT_CYCLES=0.
//    WAIT: counter decrements each cycle. At count 1 the next state is RESP.
//    RESP: ready=1 for exactly this cycle, then IDLE.
//  - Latency: ready rises WAIT_CYCLES+1 cycles after the accept edge.
//    No back-to-back accept: the next request can be accepted in the first IDLE cycle after RESP.
//  - busy=1 in WAIT and RESP. ena in WAIT/RESP is ignored; it is not queued.
//  - Word index = addra[DEPTH_LOG2+1:2]. Higher address bits are ignored, so addresses alias modulo 4*2^DEPTH_LOG2.
//  - Write: on the edge entering RESP, each lane i with wea[i]=1 is updated. Other lanes are kept.
//  - douta is updated on the edge entering RESP, for reads and writes:
//    - read: current word;
//    - write: merged post-write word (write-first).
//    douta holds its value outside RESP until the next completion.
//  - addra/wea/dina changes after accept have no effect on the request in flight.
// CONFIGURATION
//  DMEM_ALIGN_CHECK_EN defined:
//    - a request is misaligned if any wea[i]=1 with addra[1:0]!=0, or if it is a read with addra[1:0]!=0;
//    - a misaligned request takes the same latency, no storage update, douta=0, err=1 with ready.
//  DMEM_ALIGN_CHECK_EN undefined: addra[1:0] is ignored; err is tied to 0.
// TESTING
//  Run every case with WAIT_CYCLES=0, 1 and 3.
//  1 Write then read:
//    - write addra=0x10 wea=4'hF dina=0xDEADBEEF, then read addra=0x10;
//    - each ready arrives WAIT_CYCLES+1 cycles after accept;
//    - douta=0xDEADBEEF.
//  2 Byte merge:
//    - word 0x20 holds 0x11223344; write wea=4'b0100 dina=0xAABBCCDD;
//    - read returns 0x11BB3344.
//  3 Busy drop: pulse ena with a write to 0x30 while busy=1 -> no ready for it; word 0x30 unchanged.
//  4 Aliasing: DEPTH_LOG2=10; write 0x1000_0008=0x5A5A5A5A -> read 0x0000_0008 returns 0x5A5A5A5A.
//  5 Reset mid-op: WAIT_CYCLES=3, assert rst low 1 cycle after a write accept ->
//    - outputs go to 0 immediately;
//    - the write is not committed.
//  6 DMEM_ALIGN_CHECK_EN: write addra=0x41 wea=4'hF ->
//    - err=1 and ready=1 in the same cycle, douta=0;
//    - word 0x40 unchanged.
//    Without the macro: err=0 and the write lands at 0x40.

Source files
------------

// File: rtl/data_ram_resp.sv
// data_ram_resp: CPU data-memory slave, word storage with byte-lane writes; optional DMEM_ALIGN_CHECK_EN.
// Latency: ready pulses WAIT_CYCLES+1 cycles after the accept edge (counting the accept cycle); one request in flight.
// Backpressure: none queued; ena is ignored while busy, so the CPU must hold off until ready has pulsed.
module data_ram_resp #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [3:0]  wea,
  input  logic [31:0] addra,
  input  logic [31:0] dina,
  output logic [31:0] douta,
  output logic        ready,
  output logic        busy,
  output logic        err
);
  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  accept;
  logic                  enter_resp;
  logic [DEPTH_LOG2-1:0] idx_q, cur_idx;
  logic [3:0]            wea_q, cur_wea;
  logic [31:0]           din_q, cur_din;
  logic                  cur_mis;
  logic [31:0]           rd_word, merged;
  logic [31:0]           douta_q;
  logic [31:0]           mem [DEPTH];
  logic                  unused_addr;

  assign unused_addr = ^{addra[31:DEPTH_LOG2+2], addra[1:0]};

  assign accept = (state_q == S_IDLE) && ena;

  // A zero-wait request completes on its own accept edge, so in IDLE the data path uses the live inputs.
  assign cur_idx = accept ? addra[DEPTH_LOG2+1:2] : idx_q;
  assign cur_wea = accept ? wea : wea_q;
  assign cur_din = accept ? dina : din_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ena) begin
          cnt_d = WAIT_INIT;
          if (WAIT_INIT == 4'd0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wea_q   <= 4'd0;
      din_q   <= 32'd0;
      douta_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q <= addra[DEPTH_LOG2+1:2];
        wea_q <= wea;
        din_q <= dina;
      end
      if (enter_resp) douta_q <= cur_mis ? 32'd0 : merged;
    end
  end

  // Write-first merge: the response carries the word as it is after this request's byte lanes land.
  assign rd_word = mem[cur_idx];

  always_comb begin
    merged = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (cur_wea[i]) merged[8*i +: 8] = cur_din[8*i +: 8];
    end
  end

  // Storage is never reset; the rst term keeps an in-flight write from landing while reset is held.
  always_ff @(posedge clk) begin
    if (rst && enter_resp && !cur_mis && (cur_wea != 4'b0000)) mem[cur_idx] <= merged;
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic mis_q;
  logic err_q;

  assign cur_mis = accept ? (addra[1:0] != 2'b00) : mis_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mis_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (accept)     mis_q <= (addra[1:0] != 2'b00);
      if (enter_resp) err_q <= cur_mis;
    end
  end

  assign err = (state_q == S_RESP) && err_q;
`else
  assign cur_mis = 1'b0;
  assign err     = 1'b0;
`endif

  assign douta = douta_q;
  assign ready = (state_q == S_RESP);
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_ram_resp.sv
// Bench for data_ram_resp: three instances (WAIT_CYCLES 0, 1, 3) driven with directed and random traffic,
// responses checked by a per-instance scoreboard against a word-array reference model.
module tb_data_ram_resp;
  localparam int DL = 10;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  typedef struct {
    logic [31:0] dat;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   lanes_done = 0;

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input int w, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s (WAIT_CYCLES=%0d): got %h, expected %h", nm, w, got, want);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int W = (g == 0) ? 0 : ((g == 1) ? 1 : 3);

    logic        rst;
    logic        ena;
    logic [3:0]  wea;
    logic [31:0] addra;
    logic [31:0] dina;
    logic [31:0] douta;
    logic        ready;
    logic        busy;
    logic        err;

    exp_t        q[$];
    logic [31:0] mdl [int];
    int          init_words[14] = '{2, 4, 8, 12, 16, 20, 100, 101, 102, 103, 104, 105, 106, 107};
    logic [31:0] old_word;
    logic [31:0] ra;
    logic [3:0]  rwe;
    int          n;

    data_ram_resp #(.DEPTH_LOG2(DL), .WAIT_CYCLES(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .ena   (ena),
      .wea   (wea),
      .addra (addra),
      .dina  (dina),
      .douta (douta),
      .ready (ready),
      .busy  (busy),
      .err   (err)
    );

    task automatic wait_idle();
      int k = 0;
      while (busy && k < 64) begin
        @(negedge clk);
        k++;
      end
      chk("idle_wait", W, {31'd0, busy}, 32'd0);
    endtask

    // Reference: memory is an array of words indexed by address/4 modulo depth; response is the post-write word.
    task automatic issue(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
      exp_t        e;
      int          idx;
      logic [31:0] nw;
      bit          mis;
      wait_idle();
      idx = int'((a >> 2) % (32'd1 << DL));
      mis = ALIGN && ((a % 4) != 0);
      nw  = mdl[idx];
      for (int i = 0; i < 4; i++) if (we[i]) nw[8*i +: 8] = d[8*i +: 8];
      e.dat = mis ? 32'd0 : nw;
      e.err = mis;
      e.cyc = cyc + 1 + W;
      if (!mis) mdl[idx] = nw;
      q.push_back(e);
      ena   = 1'b1;
      wea   = we;
      addra = a;
      dina  = d;
      @(negedge clk);
      ena   = 1'b0;
      wea   = 4'($urandom);
      addra = $urandom;
      dina  = $urandom;
      chk("busy_after_accept", W, {31'd0, busy}, 32'd1);
    endtask

    initial forever begin
      exp_t e;
      @(negedge clk);
      if (rst === 1'b1 && ready === 1'b1) begin
        chk("ready_has_pending_request", W, {31'd0, q.size() != 0}, 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("douta", W, douta, e.dat);
          chk("err", W, {31'd0, err}, {31'd0, e.err});
          chk("latency_cycle", W, 32'(cyc), 32'(e.cyc));
        end
      end
    end

    initial begin
      rst = 1'b0; ena = 1'b0; wea = 4'd0; addra = 32'd0; dina = 32'd0;
      repeat (2) @(negedge clk);
      chk("reset_douta", W, douta, 32'd0);
      chk("reset_ready", W, {31'd0, ready}, 32'd0);
      chk("reset_busy",  W, {31'd0, busy},  32'd0);
      chk("reset_err",   W, {31'd0, err},   32'd0);
      rst = 1'b1;
      @(negedge clk);

      foreach (init_words[i]) issue(32'(init_words[i] * 4), 4'hF, $urandom);

      // write then read
      issue(32'h10, 4'hF, 32'hDEADBEEF);
      issue(32'h10, 4'h0, $urandom);

      // byte-lane merge
      issue(32'h20, 4'hF, 32'h11223344);
      issue(32'h20, 4'b0100, 32'hAABBCCDD);
      issue(32'h20, 4'h0, $urandom);

      // request while busy is dropped
      issue(32'h10, 4'h0, 32'd0);
      ena = 1'b1; wea = 4'hF; addra = 32'h30; dina = ~mdl[12];
      @(negedge clk);
      ena = 1'b0;
      issue(32'h30, 4'h0, 32'd0);

      // address aliasing
      issue(32'h1000_0008, 4'hF, 32'h5A5A5A5A);
      issue(32'h0000_0008, 4'h0, 32'd0);

      // reset one cycle after a write accept; only a zero-wait write has completed by then
      old_word = mdl[20];
      issue(32'h50, 4'hF, ~old_word);
      #2 rst = 1'b0;
      if (W != 0) begin
        q.delete(q.size() - 1);
        mdl[20] = old_word;
      end
      #1;
      chk("midop_reset_douta", W, douta, 32'd0);
      chk("midop_reset_ready", W, {31'd0, ready}, 32'd0);
      chk("midop_reset_busy",  W, {31'd0, busy},  32'd0);
      chk("midop_reset_err",   W, {31'd0, err},   32'd0);
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      issue(32'h50, 4'h0, 32'd0);

      // misaligned write
      issue(32'h41, 4'hF, 32'hCAFEF00D);
      issue(32'h40, 4'h0, 32'd0);

      repeat (40) begin
        ra = ($urandom & ~32'h0000_0FFC) | (32'($urandom_range(100, 107)) << 2);
        if ($urandom_range(0, 1) == 0) ra[1:0] = 2'b00;
        rwe = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
        issue(ra, rwe, $urandom);
        if ($urandom_range(0, 3) == 0) begin
          ena = 1'b1; wea = 4'hF; addra = $urandom; dina = $urandom;
          @(negedge clk);
          ena = 1'b0;
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      n = 0;
      while (q.size() != 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("drain_pending", W, 32'(q.size()), 32'd0);
      lanes_done++;
    end
  end

  initial begin
    int k = 0;
    while (lanes_done < 3 && k < 20000) begin
      @(posedge clk);
      k++;
    end
    checks++;
    if (lanes_done < 3) begin
      errors++;
      $display("FAIL global_timeout: lanes finished %0d, expected 3", lanes_done);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
